sc_speed_stepper: RTL and testbench
===================================

# sc_speed_stepper

Speed controller that sits directly downstream of the 26-bit velocity tick counter. It consumes that counter's active-low end-of-count tick and turns it into one-cycle game-step pulses, whose rate depends on a player-controlled speed level. It also drives the counter's clear input, so the tick source is held in reset while the game is idle. A three-state FSM (IDLE/RUN/CRASH) handles start, accelerate, brake and collision recovery.

## Interface
- LEVEL_WIDTH, 3: width of speed level.
- MAX_LEVEL, 7: top speed level, must be < 2^LEVEL_WIDTH.
- HOLD_TICKS, 4: tick events a button must be held per level change.
- CRASH_TICKS, 8: tick events spent frozen after a crash.
- SC_COUNTER_CLOCK_50  in  1  system clock, 50 MHz.
- SC_COUNTER_RESET_InLow  in  1  reset, asynchronous, active-low.
- SC_SPEED_tick_InLow  in  1  eoc from velocity counter; low = tick.
- SC_SPEED_start_InLow  in  1  start request, active-low level.
- SC_SPEED_accel_InLow  in  1  accelerate button, active-low, already debounced.
- SC_SPEED_brake_InLow  in  1  brake button, active-low, already debounced.
- SC_SPEED_crash_InLow  in  1  collision flag, active-low.
- SC_SPEED_step_OutLow  out  1  one-cycle low pulse per game step.
- SC_SPEED_level_Out  out  LEVEL_WIDTH  current speed level.
- SC_SPEED_clear_Out  out  1  high = clear velocity counter (drives its count_InLow).
- SC_SPEED_state_Out  out  2  FSM state: 00 IDLE, 01 RUN, 10 CRASH.

## Operation
- Tick event: tick_InLow low now and high last cycle. This is edge-detected; a low held for N cycles counts as one event. The previous-value register resets to 1.
- IDLE (reset state):
  - level=0, clear_Out=1, no steps.
  - start low → RUN, level=1, all counters 0.
- RUN:
  - clear_Out=0.
  - Per cycle priority: crash > brake > accel.
  - crash low → CRASH, level=0, crash_cnt=0.
  - brake held: hold_cnt counts tick events. When it reaches HOLD_TICKS, level decrements (saturating at 0) and hold_cnt=0.
  - accel held, brake not held: same counting, level increments (saturating at MAX_LEVEL).
  - Held button changes, or both buttons released: hold_cnt=0.
  - start ignored.
- Step generation (RUN only):
  - On each tick event with level>0: if div_cnt ≥ MAX_LEVEL−level, issue a step and set div_cnt=0; else div_cnt+1.
  - level=MAX_LEVEL → step on every tick. level=1 → step every MAX_LEVEL ticks. level=0 → no steps, div_cnt held 0.
  - div_cnt is not cleared on a level change; the ≥ compare absorbs a level rise.
- CRASH:
  - level=0, steps suppressed, clear_Out=0 (ticks keep flowing).
  - crash_cnt counts tick events. On reaching CRASH_TICKS → RUN, level=1, div_cnt=0, hold_cnt=0.
  - Further crash assertions ignored; no restart of crash_cnt.
- Width rules: div_cnt, hold_cnt, crash_cnt are sized by $clog2 of their bound. All arithmetic is unsigned with no wrap (saturating or cleared before overflow).

## Timing
- All outputs registered. Reset values: step_OutLow=1, level=0, clear_Out=1, state=00.
- step_OutLow goes low exactly one cycle after the tick event cycle, for exactly one cycle.
- level/state update one cycle after the causing tick event or input sample.
- Reset mid-operation: immediate asynchronous return to IDLE values. The tick-edge register returns to 1.
- Crash and tick event in the same RUN cycle: crash wins, no step issued.
- Last crash tick event: CRASH→RUN transition only; no step in that cycle.

## Configuration
- SC_SPEED_COAST_EN defined: in RUN with neither button held, level decrements by 1 every HOLD_TICKS tick events, saturating at 1 (never stalls).
- Not defined: level holds when no button is pressed.

## Structure
- Shared package `sc_speed_pkg`:
  - state encoding constants (IDLE, RUN, CRASH);
  - default parameter values.
- One sub-module, `sc_tick_edge`: a 1-bit active-low falling-edge detector with async reset. It is reused for the tick input.
- The FSM, the counters and the output registers stay in the top module.

## Test plan
- Reset then start low for 1 cycle → state 01, level 1, clear_Out 0. With defaults, 7 tick events yield exactly 1 step, one cycle after the 7th tick.
- accel held for 24 tick events from level 1 → level 7; afterwards one step per tick, each step 1 cycle late; level saturates at 7 with accel still held.
- accel and brake held together for 4 ticks at level 3 → level 2 (brake priority).
- crash low at level 5, coincident with a tick → no step, state 10, level 0. After 8 tick events → state 01, level 1. A crash pulse mid-CRASH does not extend the freeze.
- tick_InLow held low 5 cycles → counted as one event only.
- Async reset asserted mid-RUN at level 4 → outputs immediately 1/0/1/00. With SC_SPEED_COAST_EN and no buttons held, level 4 → 1 after 12 tick events and stays at 1.

Source files
------------

// File: rtl/sc_speed_pkg.sv
// Shared definitions for the speed stepper: FSM state encoding,
// held-button tracking and default parameter values.
package sc_speed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CRASH = 2'b10
    } sc_state_e;

    typedef enum logic [1:0] {
        HELD_NONE  = 2'b00,
        HELD_BRAKE = 2'b01,
        HELD_ACCEL = 2'b10
    } sc_held_e;

    localparam int SC_LEVEL_WIDTH_DEF = 3;
    localparam int SC_MAX_LEVEL_DEF   = 7;
    localparam int SC_HOLD_TICKS_DEF  = 4;
    localparam int SC_CRASH_TICKS_DEF = 8;

endpackage

// File: rtl/sc_tick_edge.sv
// Active-low falling-edge detector: fall is high for the single cycle in
// which sig_n is low and was high on the previous cycle. The history
// register resets to 1 so a low input right after reset counts as an edge.
module sc_tick_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_n,
    output logic fall
);

    logic prev;

    // Remember last cycle's input level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= sig_n;
    end

    assign fall = prev & ~sig_n;

endmodule

// File: rtl/sc_speed_stepper.sv
// Speed controller downstream of the velocity tick counter. Turns tick
// events into game-step pulses at a rate set by the speed level, and runs
// the IDLE/RUN/CRASH FSM. Optional macro SC_SPEED_COAST_EN: with no button
// held in RUN, level decays by one every HOLD_TICKS tick events down to 1.
module sc_speed_stepper
    import sc_speed_pkg::*;
#(
    parameter int LEVEL_WIDTH = SC_LEVEL_WIDTH_DEF,
    parameter int MAX_LEVEL   = SC_MAX_LEVEL_DEF,
    parameter int HOLD_TICKS  = SC_HOLD_TICKS_DEF,
    parameter int CRASH_TICKS = SC_CRASH_TICKS_DEF
) (
    input  logic                   SC_COUNTER_CLOCK_50,
    input  logic                   SC_COUNTER_RESET_InLow,
    input  logic                   SC_SPEED_tick_InLow,
    input  logic                   SC_SPEED_start_InLow,
    input  logic                   SC_SPEED_accel_InLow,
    input  logic                   SC_SPEED_brake_InLow,
    input  logic                   SC_SPEED_crash_InLow,
    output logic                   SC_SPEED_step_OutLow,
    output logic [LEVEL_WIDTH-1:0] SC_SPEED_level_Out,
    output logic                   SC_SPEED_clear_Out,
    output logic [1:0]             SC_SPEED_state_Out
);

    localparam int DIV_W   = (MAX_LEVEL   > 1) ? $clog2(MAX_LEVEL)   : 1;
    localparam int HOLD_W  = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
    localparam int CRASH_W = (CRASH_TICKS > 1) ? $clog2(CRASH_TICKS) : 1;

    localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE = LEVEL_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = LEVEL_WIDTH'(MAX_LEVEL);

    sc_state_e              state_q, state_d;
    sc_held_e               held_q, held_now;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [HOLD_W-1:0]      hold_q, hold_d, hold_base;
    logic [CRASH_W-1:0]     crash_q, crash_d;
    logic                   step_q, step_d;
    logic                   clear_q;
    logic                   tick_ev;
    logic                   hold_counts;

    sc_tick_edge u_tick_edge (
        .clk   (SC_COUNTER_CLOCK_50),
        .rst_n (SC_COUNTER_RESET_InLow),
        .sig_n (SC_SPEED_tick_InLow),
        .fall  (tick_ev)
    );

    // Which button currently owns the hold counter (brake has priority).
    always_comb begin
        held_now = HELD_NONE;
        if (!SC_SPEED_brake_InLow)      held_now = HELD_BRAKE;
        else if (!SC_SPEED_accel_InLow) held_now = HELD_ACCEL;
    end

    // Hold counter only advances while a button is held, or always when coasting.
`ifdef SC_SPEED_COAST_EN
    assign hold_counts = 1'b1;
`else
    assign hold_counts = (held_now != HELD_NONE);
`endif

    // Next-state, counter and output logic.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        div_d     = div_q;
        hold_d    = hold_q;
        crash_d   = crash_q;
        step_d    = 1'b0;
        // A change of held button restarts the count; the current event
        // then counts as the first one of the new hold.
        hold_base = (held_now != held_q) ? '0 : hold_q;

        case (state_q)
            ST_IDLE: begin
                level_d = '0;
                div_d   = '0;
                hold_d  = '0;
                crash_d = '0;
                if (!SC_SPEED_start_InLow) begin
                    state_d = ST_RUN;
                    level_d = LEVEL_ONE;
                end
            end

            ST_RUN: begin
                if (!SC_SPEED_crash_InLow) begin
                    state_d = ST_CRASH;
                    level_d = '0;
                    crash_d = '0;
                    hold_d  = '0;
                end else begin
                    if (level_q == '0) begin
                        div_d = '0;
                    end else if (tick_ev) begin
                        if (int'(div_q) >= MAX_LEVEL - int'(level_q)) begin
                            step_d = 1'b1;
                            div_d  = '0;
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end

                    hold_d = hold_base;
                    if (tick_ev && hold_counts) begin
                        if (int'(hold_base) >= HOLD_TICKS - 1) begin
                            hold_d = '0;
                            case (held_now)
                                HELD_BRAKE: if (level_q != '0)       level_d = level_q - LEVEL_ONE;
                                HELD_ACCEL: if (level_q != LEVEL_MAX) level_d = level_q + LEVEL_ONE;
                                default:    if (level_q > LEVEL_ONE)  level_d = level_q - LEVEL_ONE;
                            endcase
                        end else begin
                            hold_d = hold_base + HOLD_W'(1);
                        end
                    end
                end
            end

            ST_CRASH: begin
                level_d = '0;
                hold_d  = '0;
                if (tick_ev) begin
                    if (int'(crash_q) >= CRASH_TICKS - 1) begin
                        state_d = ST_RUN;
                        level_d = LEVEL_ONE;
                        div_d   = '0;
                        crash_d = '0;
                    end else begin
                        crash_d = crash_q + CRASH_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                level_d = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
        if (!SC_COUNTER_RESET_InLow) begin
            state_q <= ST_IDLE;
            held_q  <= HELD_NONE;
            level_q <= '0;
            div_q   <= '0;
            hold_q  <= '0;
            crash_q <= '0;
            step_q  <= 1'b1;
            clear_q <= 1'b1;
        end else begin
            state_q <= state_d;
            held_q  <= held_now;
            level_q <= level_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            crash_q <= crash_d;
            step_q  <= ~step_d;
            clear_q <= (state_d == ST_IDLE);
        end
    end

    assign SC_SPEED_step_OutLow = step_q;
    assign SC_SPEED_level_Out   = level_q;
    assign SC_SPEED_clear_Out   = clear_q;
    assign SC_SPEED_state_Out   = state_q;

endmodule

// File: tb/tb_sc_speed_stepper.sv
// Directed testbench for sc_speed_stepper with hand-computed expectations.
// Honours SC_SPEED_COAST_EN when the design is built with it.
module tb_sc_speed_stepper;

    logic       clk;
    logic       rst_n;
    logic       tick_n, start_n, accel_n, brake_n, crash_n;
    logic       step_n;
    logic [2:0] level;
    logic       clear;
    logic [1:0] state;

    int asserts;
    int failures;

    sc_speed_stepper #(
        .LEVEL_WIDTH (3),
        .MAX_LEVEL   (7),
        .HOLD_TICKS  (4),
        .CRASH_TICKS (8)
    ) dut (
        .SC_COUNTER_CLOCK_50    (clk),
        .SC_COUNTER_RESET_InLow (rst_n),
        .SC_SPEED_tick_InLow    (tick_n),
        .SC_SPEED_start_InLow   (start_n),
        .SC_SPEED_accel_InLow   (accel_n),
        .SC_SPEED_brake_InLow   (brake_n),
        .SC_SPEED_crash_InLow   (crash_n),
        .SC_SPEED_step_OutLow   (step_n),
        .SC_SPEED_level_Out     (level),
        .SC_SPEED_clear_Out     (clear),
        .SC_SPEED_state_Out     (state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance one cycle; land 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One single-cycle tick event; stepped reports the step seen right after it.
    task automatic do_tick(output logic stepped);
        tick_n = 1'b0;
        cyc();
        stepped = ~step_n;
        tick_n = 1'b1;
        cyc();
    endtask

    // Several tick events, returning how many produced a step.
    task automatic ticks(input int n, output int steps);
        logic s;
        steps = 0;
        for (int i = 0; i < n; i++) begin
            do_tick(s);
            if (s) steps++;
        end
    endtask

    task automatic start_run();
        start_n = 1'b0;
        cyc();
        start_n = 1'b1;
    endtask

    task automatic test_reset();
        logic s;
        rst_n = 1'b0;
        tick_n = 1'b1; start_n = 1'b1; accel_n = 1'b1; brake_n = 1'b1; crash_n = 1'b1;
        #25;
        asserts++; if (step_n !== 1'b1)  begin failures++; $display("FAIL reset_step got %b want 1", step_n); end
        asserts++; if (level !== 3'd0)   begin failures++; $display("FAIL reset_level got %0d want 0", level); end
        asserts++; if (clear !== 1'b1)   begin failures++; $display("FAIL reset_clear got %b want 1", clear); end
        asserts++; if (state !== 2'b00)  begin failures++; $display("FAIL reset_state got %b want 00", state); end
        cyc();
        rst_n = 1'b1;
        cyc();
        do_tick(s);
        asserts++; if (s !== 1'b0)      begin failures++; $display("FAIL idle_no_step got %b want 0", s); end
        asserts++; if (state !== 2'b00) begin failures++; $display("FAIL idle_state got %b want 00", state); end
    endtask

    task automatic test_start();
        int n;
        logic s;
        start_run();
        asserts++; if (state !== 2'b01) begin failures++; $display("FAIL start_state got %b want 01", state); end
        asserts++; if (level !== 3'd1)  begin failures++; $display("FAIL start_level got %0d want 1", level); end
        asserts++; if (clear !== 1'b0)  begin failures++; $display("FAIL start_clear got %b want 0", clear); end
        ticks(6, n);
        asserts++; if (n !== 0) begin failures++; $display("FAIL lvl1_first6 got %0d steps want 0", n); end
        tick_n = 1'b0;
        cyc();
        s = ~step_n;
        tick_n = 1'b1;
        asserts++; if (s !== 1'b1) begin failures++; $display("FAIL lvl1_7th got %b want 1", s); end
        cyc();
        asserts++; if (step_n !== 1'b1) begin failures++; $display("FAIL step_width got %b want 1", step_n); end
    endtask

    task automatic test_accel();
        int n;
        accel_n = 1'b0;
        ticks(24, n);
        asserts++; if (level !== 3'd7) begin failures++; $display("FAIL accel_to_7 got %0d want 7", level); end
        ticks(5, n);
        asserts++; if (n !== 5)        begin failures++; $display("FAIL lvl7_steps got %0d want 5", n); end
        asserts++; if (level !== 3'd7) begin failures++; $display("FAIL accel_sat got %0d want 7", level); end
        accel_n = 1'b1;
    endtask

    task automatic test_brake_priority();
        int n;
        brake_n = 1'b0;
        ticks(16, n);
        asserts++; if (level !== 3'd3) begin failures++; $display("FAIL brake_to_3 got %0d want 3", level); end
        accel_n = 1'b0;
        ticks(4, n);
        asserts++; if (level !== 3'd2) begin failures++; $display("FAIL both_to_2 got %0d want 2", level); end
        accel_n = 1'b1;
        brake_n = 1'b1;
    endtask

    task automatic test_crash();
        int n;
        logic s;
        accel_n = 1'b0;
        ticks(12, n);
        accel_n = 1'b1;
        asserts++; if (level !== 3'd5) begin failures++; $display("FAIL pre_crash_level got %0d want 5", level); end
        crash_n = 1'b0;
        tick_n = 1'b0;
        cyc();
        s = ~step_n;
        crash_n = 1'b1;
        tick_n = 1'b1;
        asserts++; if (s !== 1'b0)      begin failures++; $display("FAIL crash_no_step got %b want 0", s); end
        asserts++; if (state !== 2'b10) begin failures++; $display("FAIL crash_state got %b want 10", state); end
        asserts++; if (level !== 3'd0)  begin failures++; $display("FAIL crash_level got %0d want 0", level); end
        asserts++; if (clear !== 1'b0)  begin failures++; $display("FAIL crash_clear got %b want 0", clear); end
        cyc();
        ticks(4, n);
        crash_n = 1'b0;
        cyc();
        crash_n = 1'b1;
        cyc();
        ticks(3, n);
        asserts++; if (state !== 2'b10) begin failures++; $display("FAIL crash_after7 got %b want 10", state); end
        tick_n = 1'b0;
        cyc();
        s = ~step_n;
        tick_n = 1'b1;
        asserts++; if (s !== 1'b0)      begin failures++; $display("FAIL recover_no_step got %b want 0", s); end
        asserts++; if (state !== 2'b01) begin failures++; $display("FAIL recover_state got %b want 01", state); end
        asserts++; if (level !== 3'd1)  begin failures++; $display("FAIL recover_level got %0d want 1", level); end
        cyc();
    endtask

    task automatic test_tick_hold();
        int n;
        int lows;
        logic s;
        accel_n = 1'b0;
        ticks(24, n);
        accel_n = 1'b1;
        asserts++; if (level !== 3'd7) begin failures++; $display("FAIL hold_pre_level got %0d want 7", level); end
        lows = 0;
        tick_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (step_n === 1'b0) lows++;
        end
        tick_n = 1'b1;
        cyc();
        if (step_n === 1'b0) lows++;
        asserts++; if (lows !== 1) begin failures++; $display("FAIL long_low_steps got %0d want 1", lows); end
        do_tick(s);
        asserts++; if (s !== 1'b1) begin failures++; $display("FAIL rearm_step got %b want 1", s); end
    endtask

    task automatic test_async_reset();
        int n;
        brake_n = 1'b0;
        ticks(12, n);
        brake_n = 1'b1;
        asserts++; if (level !== 3'd4) begin failures++; $display("FAIL pre_reset_level got %0d want 4", level); end
        #5;
        rst_n = 1'b0;
        #1;
        asserts++; if (step_n !== 1'b1) begin failures++; $display("FAIL areset_step got %b want 1", step_n); end
        asserts++; if (level !== 3'd0)  begin failures++; $display("FAIL areset_level got %0d want 0", level); end
        asserts++; if (clear !== 1'b1)  begin failures++; $display("FAIL areset_clear got %b want 1", clear); end
        asserts++; if (state !== 2'b00) begin failures++; $display("FAIL areset_state got %b want 00", state); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_release();
        int n;
        start_run();
        accel_n = 1'b0;
        ticks(12, n);
        accel_n = 1'b1;
        asserts++; if (level !== 3'd4) begin failures++; $display("FAIL release_pre got %0d want 4", level); end
        ticks(12, n);
`ifdef SC_SPEED_COAST_EN
        asserts++; if (level !== 3'd1) begin failures++; $display("FAIL coast_12 got %0d want 1", level); end
        ticks(4, n);
        asserts++; if (level !== 3'd1) begin failures++; $display("FAIL coast_floor got %0d want 1", level); end
`else
        asserts++; if (level !== 3'd4) begin failures++; $display("FAIL hold_12 got %0d want 4", level); end
        ticks(4, n);
        asserts++; if (level !== 3'd4) begin failures++; $display("FAIL hold_16 got %0d want 4", level); end
`endif
    endtask

    initial begin
        asserts = 0;
        failures = 0;
        test_reset();
        test_start();
        test_accel();
        test_brake_priority();
        test_crash();
        test_tick_hold();
        test_async_reset();
        test_release();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
